// File: rtl/sw_input_pkg.sv
// Shared definitions for the switch input peripheral: register offsets,
// STATUS bit positions and the debounce FSM state encoding.
package sw_input_pkg;

  localparam logic [3:0] SW_VAL_OFF  = 4'h0;
  localparam logic [3:0] STATUS_OFF  = 4'h4;
  localparam logic [3:0] CHG_CNT_OFF = 4'h8;

  localparam int STAT_CHANGED_BIT = 0;
  localparam int STAT_IRQ_EN_BIT  = 1;

  typedef enum logic {
    S_STABLE = 1'b0,
    S_WAIT   = 1'b1
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus of quasi-static asynchronous levels.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so both stages sample the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sw_input_ctrl.sv
// Switch bank input peripheral: synchronise, debounce the whole vector and expose
// SW_VAL / STATUS / CHG_CNT on the bus. Define SW_IRQ_EN to enable the change interrupt.
module sw_input_ctrl
  import sw_input_pkg::*;
#(
  parameter int SW_WIDTH  = 24,
  parameter int DB_CYCLES = 250000,
  parameter int CNT_W     = 18
) (
  input  logic                clk_i,
  input  logic                rst_n,
  input  logic [SW_WIDTH-1:0] device_sw,
  input  logic                bus_rd_i,
  input  logic                bus_wr_i,
  input  logic [3:0]          bus_addr_i,
  input  logic [31:0]         bus_wdata_i,
  output logic [31:0]         bus_rdata_o,
  output logic                irq_o
);

  logic [SW_WIDTH-1:0] sync_q;
  logic [SW_WIDTH-1:0] stable;
  logic [SW_WIDTH-1:0] cand;
  logic [CNT_W-1:0]    cnt;
  state_t              state;
  logic                changed;
  logic                irq_en;
  logic [15:0]         chg_cnt;
  logic                accept;
  logic                wr_status;
  logic                wr_chg;
  logic                unused_wdata;

  sync_2ff #(.WIDTH(SW_WIDTH)) u_sync (
    .clk   (clk_i),
    .rst_n (rst_n),
    .d     (device_sw),
    .q     (sync_q)
  );

  // Acceptance mirrors the final branch of S_WAIT so the status logic sees the same event.
  assign accept    = (state == S_WAIT) && (sync_q == cand) && (sync_q != stable) &&
                     (cnt == CNT_W'(DB_CYCLES - 1));
  assign wr_status = bus_wr_i && (bus_addr_i == STATUS_OFF);
  assign wr_chg    = bus_wr_i && (bus_addr_i == CHG_CNT_OFF);
  assign unused_wdata = ^bus_wdata_i[31:1];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_STABLE;
      stable <= '0;
      cand   <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_STABLE: begin
          if (sync_q != stable) begin
            state <= S_WAIT;
            cand  <= sync_q;
            cnt   <= '0;
          end
        end
        S_WAIT: begin
          if (sync_q != cand) begin
            cand <= sync_q;
            cnt  <= '0;
          end else if (sync_q == stable) begin
            state <= S_STABLE;
          end else if (accept) begin
            stable <= cand;
            state  <= S_STABLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_STABLE;
      endcase
    end
  end

  // A same-cycle acceptance takes priority over the W1C and the CHG_CNT clear.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      changed <= 1'b0;
      chg_cnt <= '0;
    end else begin
      if (accept)
        changed <= 1'b1;
      else if (wr_status && bus_wdata_i[STAT_CHANGED_BIT])
        changed <= 1'b0;

      if (accept)
        chg_cnt <= wr_chg ? 16'd1 : chg_cnt + 16'd1;
      else if (wr_chg)
        chg_cnt <= '0;
    end
  end

`ifdef SW_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      irq_en <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_status)
        irq_en <= bus_wdata_i[STAT_IRQ_EN_BIT];
      irq_q <= changed & irq_en;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_en = 1'b0;
  assign irq_o  = 1'b0;
`endif

  // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
  always_comb begin
    bus_rdata_o = '0;
    if (bus_rd_i) begin
      case (bus_addr_i)
        SW_VAL_OFF:  bus_rdata_o = 32'(stable);
        STATUS_OFF: begin
          bus_rdata_o[STAT_CHANGED_BIT] = changed;
          bus_rdata_o[STAT_IRQ_EN_BIT]  = irq_en;
        end
        CHG_CNT_OFF: bus_rdata_o[15:0] = chg_cnt;
        default:     bus_rdata_o = '0;
      endcase
    end
  end

endmodule
